// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Two-player tic-tac-toe referee. Player A and player B take turns offering
// one-hot moves over a valid/ready handshake; the block checks each move,
// records it on the board, looks for a completed line and reports the result.
//
// Optional feature macro: GAME_SEQUENCER_TIMEOUT_EN
//   When defined, a player who stalls in their WAIT state for TIMEOUT_CYCLES
//   cycles forfeits the turn to the other player. When undefined, the
//   parameter and the counter do not exist and WAIT states hold indefinitely.
//
// Ports
//   clk       in   single clock, rising-edge
//   reset     in   asynchronous active-high reset
//   start     in   clears the board and begins a game (IDLE/DONE only)
//   a_valid   in   player A move request
//   a_move    in   [8:0] player A square, one-hot
//   a_ready   out  player A may move this cycle
//   b_valid   in   player B move request
//   b_move    in   [8:0] player B square, one-hot
//   b_ready   out  player B may move this cycle
//   ain       out  [8:0] squares held by A
//   bin       out  [8:0] squares held by B
//   turn      out  0 = A to move, 1 = B to move
//   win_line  out  [7:0] one-hot completed line
//                  (0:876 1:543 2:210 3:852 4:741 5:630 6:840 7:246)
//   winner    out  [1:0] 00 none, 01 A, 10 B, 11 draw
//   done      out  game over
//   illegal   out  one-cycle pulse for a rejected move
// -----------------------------------------------------------------------------
module game_sequencer
`ifdef GAME_SEQUENCER_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 64
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       a_valid,
    input  logic [8:0] a_move,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [8:0] b_move,
    output logic       b_ready,
    output logic [8:0] ain,
    output logic [8:0] bin,
    output logic       turn,
    output logic [7:0] win_line,
    output logic [1:0] winner,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_A,
        WAIT_B,
        CHECK,
        DONE
    } state_t;

    state_t     state, state_n;
    logic [8:0] ain_n, bin_n;
    logic       turn_n;
    logic [7:0] win_line_n;
    logic [1:0] winner_n;
    logic       illegal_n;

    logic       mv_valid;
    logic [8:0] mv;
    logic [8:0] occupied;
    logic       mv_onehot;
    logic       mv_legal;
    logic [7:0] mover_lines;
    logic [7:0] lowest_line;

`ifdef GAME_SEQUENCER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic             timed_out;
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Completed-line vector for one player's board, bit order as win_line.
    function automatic logic [7:0] lines_of(input logic [8:0] b);
        lines_of = {b[2] & b[4] & b[6],
                    b[8] & b[4] & b[0],
                    b[6] & b[3] & b[0],
                    b[7] & b[4] & b[1],
                    b[8] & b[5] & b[2],
                    b[2] & b[1] & b[0],
                    b[5] & b[4] & b[3],
                    b[8] & b[7] & b[6]};
    endfunction

    assign a_ready = (state == WAIT_A);
    assign b_ready = (state == WAIT_B);
    assign done    = (state == DONE);

    // Only the player on turn can present a move; the other side's valid
    // never reaches the legality check.
    assign mv_valid  = (a_valid && state == WAIT_A) || (b_valid && state == WAIT_B);
    assign mv        = (state == WAIT_B) ? b_move : a_move;
    assign occupied  = ain | bin;
    assign mv_onehot = (mv != 9'd0) && ((mv & (mv - 9'd1)) == 9'd0);
    assign mv_legal  = mv_onehot && ((mv & occupied) == 9'd0);

    // Only the player who just moved can have completed a new line, so CHECK
    // looks at the mover's board. x & -x isolates the lowest-indexed line.
    assign mover_lines = lines_of(turn ? bin : ain);
    assign lowest_line = mover_lines & (~mover_lines + 8'd1);

    // State and datapath registers; everything is computed in the
    // next-state block below and simply captured here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ain      <= 9'd0;
            bin      <= 9'd0;
            turn     <= 1'b0;
            win_line <= 8'd0;
            winner   <= 2'b00;
            illegal  <= 1'b0;
`ifdef GAME_SEQUENCER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            state    <= state_n;
            ain      <= ain_n;
            bin      <= bin_n;
            turn     <= turn_n;
            win_line <= win_line_n;
            winner   <= winner_n;
            illegal  <= illegal_n;
`ifdef GAME_SEQUENCER_TIMEOUT_EN
            wait_cnt <= wait_cnt_n;
`endif
        end
    end

    // Next-state logic. Everything holds by default; illegal is a pulse and
    // the stall counter restarts unless the block sits idle in a WAIT state.
    always_comb begin
        state_n    = state;
        ain_n      = ain;
        bin_n      = bin;
        turn_n     = turn;
        win_line_n = win_line;
        winner_n   = winner;
        illegal_n  = 1'b0;
`ifdef GAME_SEQUENCER_TIMEOUT_EN
        wait_cnt_n = '0;
`endif

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    ain_n      = 9'd0;
                    bin_n      = 9'd0;
                    win_line_n = 8'd0;
                    winner_n   = 2'b00;
                    turn_n     = 1'b0;
                    state_n    = WAIT_A;
                end
            end

            WAIT_A, WAIT_B: begin
                if (mv_valid) begin
                    if (mv_legal) begin
                        if (state == WAIT_A) begin
                            ain_n = ain | mv;
                        end else begin
                            bin_n = bin | mv;
                        end
                        state_n = CHECK;
                    end else begin
                        illegal_n = 1'b1;
                    end
                end
`ifdef GAME_SEQUENCER_TIMEOUT_EN
                else if (timed_out) begin
                    turn_n  = ~turn;
                    state_n = (state == WAIT_A) ? WAIT_B : WAIT_A;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
`endif
            end

            CHECK: begin
                // A win on the ninth move outranks the full-board draw.
                if (mover_lines != 8'd0) begin
                    win_line_n = lowest_line;
                    winner_n   = turn ? 2'b10 : 2'b01;
                    state_n    = DONE;
                end else if (occupied == 9'h1FF) begin
                    win_line_n = 8'd0;
                    winner_n   = 2'b11;
                    state_n    = DONE;
                end else begin
                    turn_n  = ~turn;
                    state_n = turn ? WAIT_A : WAIT_B;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//
// Scoreboard bench for game_sequencer. Stimulus tasks push the expected
// response of each move or start into a queue; the monitor pops an entry
// whenever the DUT presents an event (ready rising, illegal pulse or done
// rising) and compares board, turn, result and latency.
// Defining GAME_SEQUENCER_TIMEOUT_EN builds the forfeit-on-stall checks with
// TIMEOUT_CYCLES = 4 instead of the game checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_sequencer;

    localparam int K_RDY  = 0;
    localparam int K_ILL  = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int         kind;
        logic [8:0] ain;
        logic [8:0] bin;
        logic       turn;
        logic [1:0] winner;
        logic [7:0] win_line;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       a_valid;
    logic [8:0] a_move;
    logic       a_ready;
    logic       b_valid;
    logic [8:0] b_move;
    logic       b_ready;
    logic [8:0] ain;
    logic [8:0] bin;
    logic       turn;
    logic [7:0] win_line;
    logic [1:0] winner;
    logic       done;
    logic       illegal;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   ref_cyc = 0;
    logic prev_rdy  = 1'b0;
    logic prev_done = 1'b0;

`ifdef GAME_SEQUENCER_TIMEOUT_EN
    game_sequencer #(.TIMEOUT_CYCLES(4)) dut (
`else
    game_sequencer dut (
`endif
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_valid  (a_valid),
        .a_move   (a_move),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_move   (b_move),
        .b_ready  (b_ready),
        .ain      (ain),
        .bin      (bin),
        .turn     (turn),
        .win_line (win_line),
        .winner   (winner),
        .done     (done),
        .illegal  (illegal)
    );

    // Free-running clock and edge counter used for latency checks.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int kind, input logic [8:0] a, input logic [8:0] b,
                                input logic t, input logic [1:0] w, input logic [7:0] wl,
                                input int lat);
        exp_t e;
        e.kind = kind; e.ain = a; e.bin = b; e.turn = t;
        e.winner = w; e.win_line = wl; e.lat = lat;
        return e;
    endfunction

    // Monitor: detect DUT events away from the active edge and score them
    // against the oldest pending expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic rdy_rise;
        logic done_rise;
        int   kind;
        rdy_rise  = (a_ready || b_ready) && !prev_rdy;
        done_rise = done && !prev_done;
        if (!reset && (illegal || rdy_rise || done_rise)) begin
            kind = illegal ? K_ILL : (done_rise ? K_DONE : K_RDY);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: got kind %0d, expected no event", kind);
            end else begin
                e = exp_q.pop_front();
                checkOutput("event_kind", kind, e.kind);
                checkOutput("ain", ain, e.ain);
                checkOutput("bin", bin, e.bin);
                checkOutput("turn", turn, e.turn);
                checkOutput("winner", winner, e.winner);
                checkOutput("win_line", win_line, e.win_line);
                checkOutput("done", done, e.kind == K_DONE);
                checkOutput("a_ready", a_ready, (e.kind != K_DONE) && !e.turn);
                checkOutput("b_ready", b_ready, (e.kind != K_DONE) && e.turn);
                if (e.lat >= 0) checkOutput("latency", cyc - ref_cyc, e.lat);
            end
        end
        prev_rdy  <= a_ready || b_ready;
        prev_done <= done;
    end

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pending_events", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_ain"}, ain, 0);
        checkOutput({name, "_bin"}, bin, 0);
        checkOutput({name, "_win_line"}, win_line, 0);
        checkOutput({name, "_winner"}, winner, 0);
        checkOutput({name, "_turn"}, turn, 0);
        checkOutput({name, "_done"}, done, 0);
        checkOutput({name, "_illegal"}, illegal, 0);
        checkOutput({name, "_a_ready"}, a_ready, 0);
        checkOutput({name, "_b_ready"}, b_ready, 0);
    endtask

    // Pulse start for one edge; when accepted A's ready rises at that edge.
    task automatic start_game(input logic push);
        @(negedge clk);
        if (push) exp_q.push_back(mk(K_RDY, 9'h000, 9'h000, 1'b0, 2'b00, 8'h00, 0));
        start = 1'b1;
        @(posedge clk);
        #1;
        ref_cyc = cyc;
        start = 1'b0;
        wait_drain();
    endtask

    // Offer one move from a player, hold it until consumed, then wait for
    // the scored response.
    task automatic applyStimulus(input logic player, input logic [8:0] move,
                                 input logic push, input exp_t e);
        int n = 0;
        @(negedge clk);
        if (player) begin
            b_valid = 1'b1;
            b_move  = move;
        end else begin
            a_valid = 1'b1;
            a_move  = move;
        end
        while (!(player ? b_ready : a_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", n < 20, 1);
        if (n < 20) begin
            if (push) exp_q.push_back(e);
            @(posedge clk);
            #1;
            ref_cyc = cyc;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_move  = 9'h000;
        b_move  = 9'h000;
        if (push) wait_drain();
    endtask

    task automatic play(input logic player, input logic [8:0] move, input int kind,
                        input logic [8:0] a, input logic [8:0] b, input logic t,
                        input logic [1:0] w, input logic [7:0] wl);
        applyStimulus(player, move, 1'b1, mk(kind, a, b, t, w, wl, (kind == K_ILL) ? 0 : 1));
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        reset   = 1'b1;
        start   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_move  = 9'h000;
        b_move  = 9'h000;
        repeat (2) @(negedge clk);
        checkReset("por");
        reset = 1'b0;
        @(negedge clk);

`ifdef GAME_SEQUENCER_TIMEOUT_EN
        $display("[TB] timeout: A stalls, turn passes to B");
        start_game(1'b1);
        exp_q.push_back(mk(K_RDY, 9'h000, 9'h000, 1'b1, 2'b00, 8'h00, 4));
        wait_drain();
        $display("[TB] timeout: B moves, then A stalls again");
        play(1'b1, 9'h001, K_RDY, 9'h000, 9'h001, 1'b0, 2'b00, 8'h00);
        exp_q.push_back(mk(K_RDY, 9'h000, 9'h001, 1'b1, 2'b00, 8'h00, 5));
        wait_drain();
`else
        $display("[TB] game 1: A wins on diagonal 840");
        start_game(1'b1);
        play(1'b0, 9'h100, K_RDY, 9'h100, 9'h000, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h080, K_RDY, 9'h100, 9'h080, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h010, K_RDY, 9'h110, 9'h080, 1'b1, 2'b00, 8'h00);
        start_game(1'b0);
        checkOutput("start_ignored_ain", ain, 9'h110);
        checkOutput("start_ignored_b_ready", b_ready, 1);
        @(negedge clk);
        a_valid = 1'b1;
        a_move  = 9'h001;
        repeat (3) @(negedge clk);
        a_valid = 1'b0;
        a_move  = 9'h000;
        checkOutput("off_turn_ain", ain, 9'h110);
        checkOutput("off_turn_b_ready", b_ready, 1);
        play(1'b1, 9'h040, K_RDY, 9'h110, 9'h0C0, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h001, K_DONE, 9'h111, 9'h0C0, 1'b0, 2'b01, 8'h40);
        repeat (5) @(negedge clk);
        checkOutput("hold_done", done, 1);
        checkOutput("hold_winner", winner, 2'b01);
        checkOutput("hold_win_line", win_line, 8'h40);

        $display("[TB] game 2: B wins on column 630");
        start_game(1'b1);
        play(1'b0, 9'h100, K_RDY, 9'h100, 9'h000, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h001, K_RDY, 9'h100, 9'h001, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h080, K_RDY, 9'h180, 9'h001, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h008, K_RDY, 9'h180, 9'h009, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h004, K_RDY, 9'h184, 9'h009, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h040, K_DONE, 9'h184, 9'h049, 1'b1, 2'b10, 8'h20);

        $display("[TB] game 3: draw");
        start_game(1'b1);
        play(1'b0, 9'h100, K_RDY, 9'h100, 9'h000, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h080, K_RDY, 9'h100, 9'h080, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h040, K_RDY, 9'h140, 9'h080, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h010, K_RDY, 9'h140, 9'h090, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h020, K_RDY, 9'h160, 9'h090, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h008, K_RDY, 9'h160, 9'h098, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h002, K_RDY, 9'h162, 9'h098, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h004, K_RDY, 9'h162, 9'h09C, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h001, K_DONE, 9'h163, 9'h09C, 1'b0, 2'b11, 8'h00);
        checkOutput("draw_full_board", ain | bin, 9'h1FF);

        $display("[TB] game 4: illegal moves");
        start_game(1'b1);
        play(1'b0, 9'h010, K_RDY, 9'h010, 9'h000, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h010, K_ILL, 9'h010, 9'h000, 1'b1, 2'b00, 8'h00);
        checkOutput("ill_b_ready_held", b_ready, 1);
        checkOutput("ill_pulse_cleared", illegal, 0);
        play(1'b1, 9'h011, K_ILL, 9'h010, 9'h000, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h000, K_ILL, 9'h010, 9'h000, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h001, K_RDY, 9'h010, 9'h001, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h010, K_ILL, 9'h010, 9'h001, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h001, K_ILL, 9'h010, 9'h001, 1'b0, 2'b00, 8'h00);

        $display("[TB] reset mid-game");
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkReset("rst_mid");
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] game 5: A wins row 210 on the ninth move");
        start_game(1'b1);
        play(1'b0, 9'h100, K_RDY, 9'h100, 9'h000, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h080, K_RDY, 9'h100, 9'h080, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h008, K_RDY, 9'h108, 9'h080, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h040, K_RDY, 9'h108, 9'h0C0, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h004, K_RDY, 9'h10C, 9'h0C0, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h020, K_RDY, 9'h10C, 9'h0E0, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h002, K_RDY, 9'h10E, 9'h0E0, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h010, K_RDY, 9'h10E, 9'h0F0, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h001, K_DONE, 9'h10F, 9'h0F0, 1'b0, 2'b01, 8'h04);

        $display("[TB] game 6: reset while checking A's winning move");
        start_game(1'b1);
        play(1'b0, 9'h100, K_RDY, 9'h100, 9'h000, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h080, K_RDY, 9'h100, 9'h080, 1'b0, 2'b00, 8'h00);
        play(1'b0, 9'h010, K_RDY, 9'h110, 9'h080, 1'b1, 2'b00, 8'h00);
        play(1'b1, 9'h040, K_RDY, 9'h110, 9'h0C0, 1'b0, 2'b00, 8'h00);
        applyStimulus(1'b0, 9'h001, 1'b0, mk(K_DONE, 9'h111, 9'h0C0, 1'b0, 2'b01, 8'h40, 1));
        checkOutput("check_ain", ain, 9'h111);
        checkOutput("check_a_ready", a_ready, 0);
        reset = 1'b1;
        #1;
        checkReset("rst_check");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkReset("rst_check_after");

        $display("[TB] no forfeit without the timeout build");
        start_game(1'b1);
        repeat (100) @(negedge clk);
        checkOutput("idle_a_ready", a_ready, 1);
        checkOutput("idle_turn", turn, 0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
